bin2disp_unit: RTL

Sequential binary-to-BCD converter that produces the 40-bit, 8-digit display bus consumed by the seven-segment scan driver.
- Takes an unsigned binary value on a start strobe and converts it with shift-add-3 (double dabble), one bit per cycle.
- Formats the result as eight 5-bit digit codes: 5'h00-5'h0F are glyphs, 5'h1F is blank.
- Holds the formatted word stable between conversions, so the scan driver never shows partial results.

---
 rtl/bin2disp_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/bin2disp_unit.sv
// Sequential double-dabble binary-to-BCD converter driving an 8-digit, 5-bit-per-digit display bus.
// Optional leading-zero blanking is enabled by defining BIN2DISP_LZB_EN.
module bin2disp_unit #(
  parameter int BIN_W   = 27,
  parameter int MAX_VAL = 99_999_999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [39:0]      display
);

  localparam int          CNT_W = $clog2(BIN_W);
  localparam logic [31:0] MAX_U = 32'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FORMAT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [BIN_W-1:0]   bin_r;
  logic [31:0]        bcd_r;
  logic [31:0]        adj_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               ovf_cap_r;
  logic               ovf_in_s;
  logic               busy_r, done_r, ovf_r;
  logic [39:0]        display_r;

  // Every BCD nibble of 5 or more gets +3 so the following left shift carries correctly.
  function automatic logic [31:0] add3(input logic [31:0] b);
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = (b[4*k +: 4] >= 4'd5) ? (b[4*k +: 4] + 4'd3) : b[4*k +: 4];
    end
    return r;
  endfunction

  function automatic logic [39:0] fmt_digits(input logic [31:0] bcd, input logic ovf_f);
    logic [39:0] w;
`ifdef BIN2DISP_LZB_EN
    logic lead;
    lead = 1'b1;
`endif
    w = 40'h0;
    for (int k = 0; k < 8; k++) begin
      w[5*k +: 5] = ovf_f ? 5'h0E : {1'b0, bcd[4*k +: 4]};
    end
`ifdef BIN2DISP_LZB_EN
    // Digit0 is never blanked so a zero value still shows one "0".
    if (!ovf_f) begin
      for (int k = 7; k >= 1; k--) begin
        if (lead && (bcd[4*k +: 4] == 4'h0)) begin
          w[5*k +: 5] = 5'h1F;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
    return w;
  endfunction

  // Combinational helpers: add-3 adjust and overflow decision on the raw input.
  always_comb begin
    adj_s    = add3(bcd_r);
    ovf_in_s = (32'(bin_in) > MAX_U);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == CNT_W'(0)) begin
          state_s = FORMAT;
        end else begin
          state_s = SHIFT;
        end
      end
      FORMAT:  state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath and registered outputs; display/ovf only move on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_r     <= '0;
      bcd_r     <= 32'h0;
      cnt_r     <= '0;
      ovf_cap_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ovf_r     <= 1'b0;
      display_r <= 40'hFF_FFFF_FFFF;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            bin_r     <= bin_in;
            bcd_r     <= 32'h0;
            cnt_r     <= CNT_W'(BIN_W - 1);
            ovf_cap_r <= ovf_in_s;
            busy_r    <= 1'b1;
          end
        end
        SHIFT: begin
          {bcd_r, bin_r} <= {adj_s[30:0], bin_r, 1'b0};
          if (cnt_r != CNT_W'(0)) begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        FORMAT: begin
          display_r <= fmt_digits(bcd_r, ovf_cap_r);
          ovf_r     <= ovf_cap_r;
          done_r    <= 1'b1;
          busy_r    <= 1'b0;
        end
        DONE: begin
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign ovf     = ovf_r;
  assign display = display_r;

endmodule
